// File: rtl/sobel_grad_dir_pipe.sv
// Sobel gradient stage: Gx/Gy, L1 or squared magnitude, 4-way direction, per-frame max.
// Optional low-magnitude threshold (extra port low_thr) enabled by defining SOBEL_LOW_THRESH_EN.
module sobel_grad_dir_pipe #(
  parameter  int DATA_W   = 8,
  parameter  int MAG_MODE = 0,
  localparam int G_W      = DATA_W + 3,
  localparam int MAG_W    = (MAG_MODE != 0) ? 2 * DATA_W + 5 : DATA_W + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SOBEL_LOW_THRESH_EN
  input  logic [MAG_W-1:0]      low_thr,
`endif
  input  logic [9*DATA_W-1:0]   in_win,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eof,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAG_W-1:0]      out_mag,
  output logic [1:0]            out_dir,
  output logic signed [G_W-1:0] out_gx,
  output logic signed [G_W-1:0] out_gy,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic [MAG_W-1:0]      frame_max,
  output logic                  frame_max_vld
);
  localparam int A_W = DATA_W + 2;   // |G| <= 4*(2^DATA_W-1)
  localparam int P_W = DATA_W + 12;  // wide enough for |G|*618
  localparam logic [P_W-1:0] TAN_LO = P_W'(106);  // tan(22.5) * 256
  localparam logic [P_W-1:0] TAN_HI = P_W'(618);  // tan(67.5) * 256

  typedef enum logic [1:0] {
    DIR_N  = 2'b00,
    DIR_E  = 2'b01,
    DIR_NW = 2'b10,
    DIR_NE = 2'b11
  } dir_e;

  function automatic logic signed [G_W-1:0] ext(input logic [DATA_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: gradients ----------------
  logic [DATA_W-1:0] p11, p12, p13, p21, p23, p31, p32, p33;
  assign p11 = in_win[0*DATA_W +: DATA_W];
  assign p12 = in_win[1*DATA_W +: DATA_W];
  assign p13 = in_win[2*DATA_W +: DATA_W];
  assign p21 = in_win[3*DATA_W +: DATA_W];
  assign p23 = in_win[5*DATA_W +: DATA_W];
  assign p31 = in_win[6*DATA_W +: DATA_W];
  assign p32 = in_win[7*DATA_W +: DATA_W];
  assign p33 = in_win[8*DATA_W +: DATA_W];

  logic signed [G_W-1:0] s1_gx_d, s1_gy_d, s1_gx_q, s1_gy_q;
  logic                  s1_vld_q, s1_sof_q, s1_eof_q;

  assign s1_gx_d = (ext(p13) + (ext(p23) <<< 1) + ext(p33)) - (ext(p11) + (ext(p21) <<< 1) + ext(p31));
  assign s1_gy_d = (ext(p11) + (ext(p12) <<< 1) + ext(p13)) - (ext(p31) + (ext(p32) <<< 1) + ext(p33));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset along with the valid bits because every output must read 0 after reset.
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s1_gx_q  <= '0;
      s1_gy_q  <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments let each stage capture the pre-edge value of the stage before it.
      s1_vld_q <= in_valid;
      s1_sof_q <= in_valid && in_sof;
      s1_eof_q <= in_valid && in_eof;
      if (in_valid) begin
        s1_gx_q <= s1_gx_d;
        s1_gy_q <= s1_gy_d;
      end
    end
  end

  // ---------------- S2: magnitude and tan products ----------------
  logic [A_W-1:0]        ax, ay;
  logic [MAG_W-1:0]      s2_mag_d, s2_mag_q;
  logic [P_W-1:0]        s2_t_d, s2_lo_d, s2_hi_d, s2_t_q, s2_lo_q, s2_hi_q;
  logic                  s2_same_d, s2_force_e_d, s2_same_q, s2_force_e_q;
  logic signed [G_W-1:0] s2_gx_q, s2_gy_q;
  logic                  s2_vld_q, s2_sof_q, s2_eof_q;

  always_comb begin
    // NOTE: every variable gets a value before any conditional, so no path can infer a latch.
    ax           = A_W'(s1_gx_q[G_W-1] ? -s1_gx_q : s1_gx_q);
    ay           = A_W'(s1_gy_q[G_W-1] ? -s1_gy_q : s1_gy_q);
    s2_same_d    = (s1_gx_q[G_W-1] == s1_gy_q[G_W-1]);
    s2_force_e_d = (ax == '0) && (ay == '0);
    s2_t_d       = P_W'(ay) << 8;
    s2_lo_d      = P_W'(ax) * TAN_LO;
    s2_hi_d      = P_W'(ax) * TAN_HI;
    if (MAG_MODE != 0) s2_mag_d = MAG_W'(ax) * MAG_W'(ax) + MAG_W'(ay) * MAG_W'(ay);
    else               s2_mag_d = MAG_W'(ax) + MAG_W'(ay);
`ifdef SOBEL_LOW_THRESH_EN
    // Weak gradients report zero magnitude and the neutral direction E.
    if (s2_mag_d < low_thr) begin
      s2_mag_d     = '0;
      s2_force_e_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q     <= 1'b0;
      s2_sof_q     <= 1'b0;
      s2_eof_q     <= 1'b0;
      s2_gx_q      <= '0;
      s2_gy_q      <= '0;
      s2_mag_q     <= '0;
      s2_t_q       <= '0;
      s2_lo_q      <= '0;
      s2_hi_q      <= '0;
      s2_same_q    <= 1'b0;
      s2_force_e_q <= 1'b0;
    end else if (en) begin
      s2_vld_q <= s1_vld_q;
      s2_sof_q <= s1_sof_q;
      s2_eof_q <= s1_eof_q;
      if (s1_vld_q) begin
        s2_gx_q      <= s1_gx_q;
        s2_gy_q      <= s1_gy_q;
        s2_mag_q     <= s2_mag_d;
        s2_t_q       <= s2_t_d;
        s2_lo_q      <= s2_lo_d;
        s2_hi_q      <= s2_hi_d;
        s2_same_q    <= s2_same_d;
        s2_force_e_q <= s2_force_e_d;
      end
    end
  end

  // ---------------- S3: direction and output register ----------------
  dir_e                  out_dir_d, out_dir_q;
  logic [MAG_W-1:0]      out_mag_q;
  logic signed [G_W-1:0] out_gx_q, out_gy_q;
  logic                  out_valid_q, out_sof_q, out_eof_q;

  always_comb begin
    if (s2_force_e_q)           out_dir_d = DIR_E;
    else if (s2_t_q < s2_lo_q)  out_dir_d = DIR_E;
    else if (s2_t_q >= s2_hi_q) out_dir_d = DIR_N;
    else if (s2_same_q)         out_dir_d = DIR_NE;
    else                        out_dir_d = DIR_NW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_mag_q   <= '0;
      out_dir_q   <= DIR_N;
      out_gx_q    <= '0;
      out_gy_q    <= '0;
    end else if (en) begin
      out_valid_q <= s2_vld_q;
      out_sof_q   <= s2_sof_q;
      out_eof_q   <= s2_eof_q;
      if (s2_vld_q) begin
        out_mag_q <= s2_mag_q;
        out_dir_q <= out_dir_d;
        out_gx_q  <= s2_gx_q;
        out_gy_q  <= s2_gy_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign out_mag   = out_mag_q;
  assign out_dir   = out_dir_q;
  assign out_gx    = out_gx_q;
  assign out_gy    = out_gy_q;

  // ---------------- Per-frame maximum ----------------
  logic             out_xfer;
  logic [MAG_W-1:0] run_q, run_base, run_new, frame_max_q;
  logic             frame_max_vld_q;

  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    run_base = out_sof_q ? '0 : run_q;
    run_new  = (out_mag_q > run_base) ? out_mag_q : run_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q           <= '0;
      frame_max_q     <= '0;
      frame_max_vld_q <= 1'b0;
    end else begin
      frame_max_vld_q <= 1'b0;
      if (out_xfer) begin
        if (out_eof_q) begin
          frame_max_q     <= run_new;
          frame_max_vld_q <= 1'b1;
          run_q           <= '0;
        end else begin
          run_q <= run_new;
        end
      end
    end
  end

  assign frame_max     = frame_max_q;
  assign frame_max_vld = frame_max_vld_q;

endmodule

// File: tb/tb_sobel_grad_dir_pipe.sv
// Randomised and directed bench for sobel_grad_dir_pipe (L1 and squared-magnitude instances)
// against an arithmetic reference model of the Sobel, direction and frame-max rules.
module tb_sobel_grad_dir_pipe;
  localparam int DW  = 8;
  localparam int GW  = DW + 3;
  localparam int MW0 = DW + 3;
  localparam int MW1 = 2 * DW + 5;
  localparam int D_N = 0, D_E = 1, D_NW = 2, D_NE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9*DW-1:0] in_win = '0;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b0;

  logic                 in_ready, out_valid, out_sof, out_eof, frame_max_vld;
  logic [MW0-1:0]       out_mag, frame_max;
  logic [1:0]           out_dir;
  logic signed [GW-1:0] out_gx, out_gy;

  logic                 sq_in_ready, sq_out_valid, sq_out_sof, sq_out_eof, sq_fmv;
  logic [MW1-1:0]       sq_mag, sq_fmax;
  logic [1:0]           sq_dir;
  logic signed [GW-1:0] sq_gx, sq_gy;

`ifdef SOBEL_LOW_THRESH_EN
  logic [MW0-1:0] low_thr0 = '0;
  logic [MW1-1:0] low_thr1 = '0;
`endif

  always #5 clk = ~clk;

  sobel_grad_dir_pipe #(.DATA_W(DW), .MAG_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SOBEL_LOW_THRESH_EN
    .low_thr(low_thr0),
`endif
    .in_win(in_win), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_dir(out_dir), .out_gx(out_gx), .out_gy(out_gy),
    .out_sof(out_sof), .out_eof(out_eof),
    .frame_max(frame_max), .frame_max_vld(frame_max_vld)
  );

  sobel_grad_dir_pipe #(.DATA_W(DW), .MAG_MODE(1)) dut_sq (
    .clk(clk), .rst_n(rst_n),
`ifdef SOBEL_LOW_THRESH_EN
    .low_thr(low_thr1),
`endif
    .in_win(in_win), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_ready(sq_in_ready), .out_valid(sq_out_valid), .out_ready(out_ready),
    .out_mag(sq_mag), .out_dir(sq_dir), .out_gx(sq_gx), .out_gy(sq_gy),
    .out_sof(sq_out_sof), .out_eof(sq_out_eof),
    .frame_max(sq_fmax), .frame_max_vld(sq_fmv)
  );

  typedef struct {
    int     gx;
    int     gy;
    int     mag;
    longint mag_sq;
    int     dir;
    bit     sof;
    bit     eof;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_vec = 0, n_err = 0, rx_count = 0, ready_mode = 2;
  int    run_m = 0, fmax_m = 0, mon_base = 0, mon_new = 0;
  bit    fmv_exp = 1'b0, saw_bp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  // Reference: Sobel sums, |Gx|+|Gy| and Gx^2+Gy^2, direction from the tan-comparison rules.
  function automatic beat_t model(input logic [9*DW-1:0] w, input bit sof, input bit eof);
    int    p[3][3];
    int    ax, ay;
    beat_t b;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(w[(r*3+c)*DW +: DW]);
    b.gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    b.gy = (p[0][0] + 2*p[0][1] + p[0][2]) - (p[2][0] + 2*p[2][1] + p[2][2]);
    ax = (b.gx < 0) ? -b.gx : b.gx;
    ay = (b.gy < 0) ? -b.gy : b.gy;
    b.mag    = ax + ay;
    b.mag_sq = longint'(ax) * ax + longint'(ay) * ay;
    if (ax == 0 && ay == 0)           b.dir = D_E;
    else if (ay * 256 < ax * 106)     b.dir = D_E;
    else if (ay * 256 >= ax * 618)    b.dir = D_N;
    else if ((b.gx < 0) == (b.gy < 0)) b.dir = D_NE;
    else                              b.dir = D_NW;
    b.sof = sof;
    b.eof = eof;
    return b;
  endfunction

  function automatic logic [9*DW-1:0] mk_win(input int p11, p12, p13, p21, p22, p23, p31, p32, p33);
    return {DW'(p33), DW'(p32), DW'(p31), DW'(p23), DW'(p22), DW'(p21), DW'(p13), DW'(p12), DW'(p11)};
  endfunction

  function automatic logic [9*DW-1:0] rand_win();
    logic [9*DW-1:0] w;
    int r;
    for (int i = 0; i < 9; i++) begin
      r = $urandom_range(0, 7);
      w[i*DW +: DW] = (r == 0) ? DW'(0) : (r == 1) ? DW'(255) : DW'($urandom_range(0, 255));
    end
    return w;
  endfunction

  // Monitor: compares every visible beat against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      run_m   = 0;
      fmax_m  = 0;
      fmv_exp = 1'b0;
    end else begin
      check("frame_max_vld", 64'(frame_max_vld), 64'(fmv_exp));
      if (fmv_exp) check("frame_max", 64'(frame_max), 64'(fmax_m));
      fmv_exp = 1'b0;
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 64'(out_valid), 64'(0));
        end else begin
          mon_e = exp_q[0];
          check("gx", 64'(out_gx), 64'(mon_e.gx));
          check("gy", 64'(out_gy), 64'(mon_e.gy));
          check("mag", 64'(out_mag), 64'(mon_e.mag));
          check("dir", 64'(out_dir), 64'(mon_e.dir));
          check("sof", 64'(out_sof), 64'(mon_e.sof));
          check("eof", 64'(out_eof), 64'(mon_e.eof));
          check("sq_valid", 64'(sq_out_valid), 64'(1));
          check("sq_mag", 64'(sq_mag), 64'(mon_e.mag_sq));
          if (out_ready) begin
            void'(exp_q.pop_front());
            rx_count++;
            mon_base = mon_e.sof ? 0 : run_m;
            mon_new  = (mon_e.mag > mon_base) ? mon_e.mag : mon_base;
            if (mon_e.eof) begin
              fmax_m  = mon_new;
              run_m   = 0;
              fmv_exp = 1'b1;
            end else begin
              run_m = mon_new;
            end
          end
        end
      end
      if (in_valid && !in_ready) saw_bp = 1'b1;
      if (in_valid && in_ready) exp_q.push_back(model(in_win, in_sof, in_eof));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Called and returns at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [9*DW-1:0] win, input bit sof, input bit eof);
    int guard;
    guard    = 0;
    in_win   = win;
    in_sof   = sof;
    in_eof   = eof;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      guard++;
      if (guard > 200) begin
        check("send_timeout", 64'(in_ready), 64'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [9*DW-1:0] win,
                          input int gx, input int gy, input int mag, input longint mag_sq, input int dir);
    int cyc;
    bit seen;
    send(win, 1'b0, 1'b0);
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'(3));
    check({tag, "_gx"}, 64'(out_gx), 64'(gx));
    check({tag, "_gy"}, 64'(out_gy), 64'(gy));
    check({tag, "_mag"}, 64'(out_mag), 64'(mag));
    check({tag, "_mag_sq"}, 64'(sq_mag), 64'(mag_sq));
    check({tag, "_dir"}, 64'(out_dir), 64'(dir));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard      = 0;
    ready_mode = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_mag"}, 64'(out_mag), 64'(0));
    check({tag, "_gx"}, 64'(out_gx), 64'(0));
    check({tag, "_gy"}, 64'(out_gy), 64'(0));
    check({tag, "_dir"}, 64'(out_dir), 64'(0));
    check({tag, "_sof_eof"}, 64'({out_sof, out_eof}), 64'(0));
    check({tag, "_frame_max"}, 64'(frame_max), 64'(0));
    check({tag, "_fmv"}, 64'(frame_max_vld), 64'(0));
  endtask

  initial begin
    int base_rx;
    int len;
    bit got_pulse;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 ready_mode = 0;
    @(posedge clk);
    #1;

    directed("vert", mk_win(0, 128, 255, 0, 128, 255, 0, 128, 255), 1020, 0, 1020, 64'd1040400, D_E);
    directed("horiz", mk_win(255, 255, 255, 128, 128, 128, 0, 0, 0), 0, 1020, 1020, 64'd1040400, D_N);
    directed("ne", mk_win(0, 255, 255, 0, 0, 255, 0, 0, 0), 765, 765, 1530, 64'd1170450, D_NE);
    directed("nw", mk_win(255, 255, 0, 255, 0, 0, 0, 0, 0), -765, 765, 1530, 64'd1170450, D_NW);
    directed("flat", mk_win(77, 77, 77, 77, 77, 77, 77, 77, 77), 0, 0, 0, 64'd0, D_E);
    directed("lo_edge", mk_win(0, 53, 0, 0, 0, 128, 0, 0, 0), 256, 106, 362, 64'd76772, D_NE);
    directed("hi_edge", mk_win(0, 255, 108, 0, 0, 74, 0, 0, 0), 256, 618, 874, 64'd447460, D_N);

    // Frame of four beats with magnitudes 10 / 900 / 300 / 6.
    send(mk_win(0, 0, 0, 0, 0, 5, 0, 0, 0), 1'b1, 1'b0);
    send(mk_win(0, 0, 255, 0, 0, 195, 0, 0, 0), 1'b0, 1'b0);
    send(mk_win(0, 0, 0, 0, 0, 150, 0, 0, 0), 1'b0, 1'b0);
    send(mk_win(0, 0, 0, 0, 0, 3, 0, 0, 0), 1'b0, 1'b1);
    got_pulse = 1'b0;
    for (int i = 0; i < 20 && !got_pulse; i++) begin
      @(negedge clk);
      if (frame_max_vld) got_pulse = 1'b1;
    end
    check("frame_pulse_seen", 64'(got_pulse), 64'(1));
    check("frame_max_900", 64'(frame_max), 64'(900));
    @(negedge clk);
    check("frame_pulse_width", 64'(frame_max_vld), 64'(0));
    @(posedge clk);
    #1;

    // Ten back-to-back beats with a five-cycle downstream stall in the middle.
    saw_bp  = 1'b0;
    base_rx = rx_count;
    fork
      for (int i = 0; i < 10; i++) send(rand_win(), 1'b0, 1'b0);
      begin
        repeat (4) @(posedge clk);
        ready_mode = 2;
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain();
    check("stall_rx_count", 64'(rx_count - base_rx), 64'(10));
    check("stall_backpressure", 64'(saw_bp), 64'(1));

    // Reset in the middle of a frame: in-flight beats vanish, frame max clears, no pulse.
    send(mk_win(0, 0, 0, 0, 0, 100, 0, 0, 0), 1'b1, 1'b0);
    send(mk_win(0, 0, 0, 0, 0, 60, 0, 0, 0), 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midreset_no_beat", 64'(out_valid), 64'(0));
    check("midreset_frame_max", 64'(frame_max), 64'(0));
    @(posedge clk);
    #1;

    // Random frames with random gaps and random downstream readiness.
    ready_mode = 1;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        send(rand_win(), (i == 0) && ($urandom_range(0, 7) != 0), (i == len - 1) && ($urandom_range(0, 7) != 0));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
